// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: default timing,
// hex font table, scan phase encoding and the double-buffered config record.
package seg_pkg;

   localparam int DEAD_CYCLES_DEF  = 256;
   localparam int STEP_CYCLES_DEF  = 1024;
   localparam int BLINK_CYCLES_DEF = 13500000;

   // Entry n is the gfedcba pattern for hex digit n.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      PH_DEAD,
      PH_ON,
      PH_OFF
   } phase_e;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp_mask;
      logic [3:0]  blink_mask;
      logic        blank_lz;
      logic [3:0]  bright;
   } cfg_t;

endpackage

// File: rtl/seg_font.sv
// Combinational hex nibble to gfedcba segment pattern lookup.
module seg_font
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with dead time, PWM brightness,
// frame-synchronous blink and double-buffered content.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF,
   parameter int STEP_CYCLES  = STEP_CYCLES_DEF,
   parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blink_mask,
   input  logic        blank_lz,
   input  logic [3:0]  bright,
   output logic [7:0]  seven,
   output logic [3:0]  segment,
   output logic        upd_pending,
   output logic        frame_tick
);

   phase_e      state, state_n;
   logic [1:0]  slot, slot_n;
   logic [3:0]  step, step_n;
   logic [31:0] cnt, cnt_n;
   logic [31:0] blink_cnt;
   logic        blink_phase, blink_req, blink_wrap;
   logic        boundary, dark, lz_dark;
   logic [3:0]  nib;
   logic [6:0]  font_seg;
   cfg_t        act, pend, cfg_in;

   assign cfg_in     = {digits, dp_mask, blink_mask, blank_lz, bright};
   assign boundary   = (state == PH_DEAD) && (slot == 2'd0) && (cnt == 32'd0);
   assign blink_wrap = (blink_cnt == 32'(BLINK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PH_DEAD;
         slot  <= 2'd0;
         step  <= 4'd0;
         cnt   <= 32'd0;
      end else begin
         state <= state_n;
         slot  <= slot_n;
         step  <= step_n;
         cnt   <= cnt_n;
      end
   end

   // cnt counts within the current phase (dead period or one brightness step).
   always_comb begin
      state_n = state;
      slot_n  = slot;
      step_n  = step;
      cnt_n   = cnt + 32'd1;
      case (state)
         PH_DEAD: begin
            if (cnt == 32'(DEAD_CYCLES - 1)) begin
               cnt_n   = 32'd0;
               step_n  = 4'd0;
               state_n = PH_ON;
            end
         end
         default: begin
            if (cnt == 32'(STEP_CYCLES - 1)) begin
               cnt_n = 32'd0;
               if (step == 4'd15) begin
                  step_n  = 4'd0;
                  slot_n  = slot + 2'd1;
                  state_n = PH_DEAD;
               end else begin
                  step_n  = step + 4'd1;
                  state_n = (step_n <= act.bright) ? PH_ON : PH_OFF;
               end
            end
         end
      endcase
   end

   // A load on the boundary itself skips the pending stage entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         act         <= '{digits: 16'h0, dp_mask: 4'h0, blink_mask: 4'h0,
                          blank_lz: 1'b0, bright: 4'hF};
         pend        <= '{digits: 16'h0, dp_mask: 4'h0, blink_mask: 4'h0,
                          blank_lz: 1'b0, bright: 4'hF};
         upd_pending <= 1'b0;
      end else if (boundary && load) begin
         act         <= cfg_in;
         upd_pending <= 1'b0;
      end else if (boundary && upd_pending) begin
         act         <= pend;
         upd_pending <= 1'b0;
      end else if (load) begin
         pend        <= cfg_in;
         upd_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= 32'd0;
         blink_req   <= 1'b0;
         blink_phase <= 1'b0;
      end else begin
         blink_cnt   <= blink_wrap ? 32'd0 : blink_cnt + 32'd1;
         blink_req   <= blink_wrap || (blink_req && !boundary);
         if (boundary && blink_req)
            blink_phase <= ~blink_phase;
      end
   end

   assign nib     = act.digits[{slot, 2'b00} +: 4];
   assign lz_dark = act.blank_lz && (act.digits[15:12] == 4'd0) &&
                    ((slot == 2'd3) || ((slot == 2'd2) && (act.digits[11:8] == 4'd0)));
   assign dark    = (blink_phase && act.blink_mask[slot]) || lz_dark;

   seg_font u_font (
      .nibble (nib),
      .seg    (font_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         seven      <= 8'h00;
         segment    <= 4'h0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if ((state == PH_ON) && !dark) begin
            seven   <= {act.dp_mask[slot], font_seg};
            segment <= 4'b0001 << slot;
         end else begin
            seven   <= 8'h00;
            segment <= 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: hand-derived checkpoint table plus randomized
// traffic, every cycle compared against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int DEAD  = 2;
   localparam int STEP  = 1;
   localparam int BLINK = 40;
   localparam int SLOT  = DEAD + 16 * STEP;
   localparam int FRAME = 4 * SLOT;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  blink;
      logic        blz;
      logic [3:0]  bright;
   } mcfg_t;

   typedef struct {
      logic       rst;
      logic       load;
      mcfg_t      cfg;
      int         edges;
      logic [7:0] exp_seven;
      logic [3:0] exp_segment;
      logic       exp_tick;
      logic       exp_upd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, load, blank_lz;
   logic [15:0] digits;
   logic [3:0]  dp_mask, blink_mask, bright;
   logic [7:0]  seven;
   logic [3:0]  segment;
   logic        upd_pending, frame_tick;

   int checks   = 0;
   int failures = 0;

   logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   mcfg_t      m_act, m_pend;
   logic       m_upd, m_phase, m_req;
   int         m_bcnt, m_pos;
   logic [7:0] exp_seven;
   logic [3:0] exp_segment;
   logic       exp_tick, exp_upd;
   vec_t       vecs[$];

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .DEAD_CYCLES  (DEAD),
      .STEP_CYCLES  (STEP),
      .BLINK_CYCLES (BLINK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .digits      (digits),
      .dp_mask     (dp_mask),
      .blink_mask  (blink_mask),
      .blank_lz    (blank_lz),
      .bright      (bright),
      .seven       (seven),
      .segment     (segment),
      .upd_pending (upd_pending),
      .frame_tick  (frame_tick)
   );

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Predicts the outputs produced by the coming edge from the frame position,
   // then advances buffers, blink state and position.
   task automatic modelEdge();
      int   slot, c, k;
      logic lit;
      mcfg_t cur;
      cur = {digits, dp_mask, blink_mask, blank_lz, bright};
      if (rst) begin
         m_act  = '{digits: 16'h0, dp: 4'h0, blink: 4'h0, blz: 1'b0, bright: 4'hF};
         m_pend = m_act;
         m_upd = 1'b0; m_phase = 1'b0; m_req = 1'b0; m_bcnt = 0; m_pos = 0;
         exp_seven = 8'h00; exp_segment = 4'h0; exp_tick = 1'b0; exp_upd = 1'b0;
         return;
      end
      slot = m_pos / SLOT;
      c    = m_pos % SLOT;
      exp_tick = (m_pos == 0);
      lit = 1'b0;
      if (c >= DEAD) begin
         k   = (c - DEAD) / STEP;
         lit = (k <= int'(m_act.bright));
      end
      if (m_phase && m_act.blink[slot]) lit = 1'b0;
      if (m_act.blz && m_act.digits[15:12] == 4'd0 && slot == 3) lit = 1'b0;
      if (m_act.blz && m_act.digits[15:8] == 8'd0 && slot == 2) lit = 1'b0;
      if (lit) begin
         exp_segment = 4'(1 << slot);
         exp_seven   = {m_act.dp[slot], font_tab[m_act.digits[slot*4 +: 4]]};
      end else begin
         exp_segment = 4'h0;
         exp_seven   = 8'h00;
      end
      if (m_pos == 0 && load) begin
         m_act = cur;
         m_upd = 1'b0;
      end else begin
         if (m_pos == 0 && m_upd) begin
            m_act = m_pend;
            m_upd = 1'b0;
         end
         if (load) begin
            m_pend = cur;
            m_upd  = 1'b1;
         end
      end
      if (m_pos == 0 && m_req) begin
         m_phase = ~m_phase;
         m_req   = 1'b0;
      end
      if (m_bcnt == BLINK - 1) begin
         m_bcnt = 0;
         m_req  = 1'b1;
      end else begin
         m_bcnt++;
      end
      exp_upd = m_upd;
      m_pos   = (m_pos + 1) % FRAME;
   endtask

   task automatic applyStimulus(input logic r, input logic l, input mcfg_t cfg);
      @(negedge clk);
      rst = r; load = l;
      {digits, dp_mask, blink_mask, blank_lz, bright} = cfg;
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput("model_seven", seven, exp_seven);
      checkOutput("model_segment", {4'h0, segment}, {4'h0, exp_segment});
      checkOutput("model_tick", {7'h0, frame_tick}, {7'h0, exp_tick});
      checkOutput("model_upd", {7'h0, upd_pending}, {7'h0, exp_upd});
   endtask

   task automatic addVec(input logic r, input logic l, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic blz, input logic [3:0] br, input int n,
                         input logic [7:0] s, input logic [3:0] g, input logic t, input logic u);
      vec_t v;
      v.rst = r; v.load = l; v.cfg = {d, dp, bl, blz, br}; v.edges = n;
      v.exp_seven = s; v.exp_segment = g; v.exp_tick = t; v.exp_upd = u;
      vecs.push_back(v);
   endtask

   initial begin
      mcfg_t rc;
      rst = 1'b1; load = 1'b0; digits = '0; dp_mask = '0; blink_mask = '0;
      blank_lz = 1'b0; bright = '0;

      // rst load digits  dp bl lz br edges  seven seg tick upd
      addVec(1, 0, 16'h0000, 0, 0, 0, 0,  3, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h1234, 0, 0, 0, 15, 3, 8'h66, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h4F, 4'h2, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h5B, 4'h4, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h06, 4'h8, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 16, 8'h00, 4'h0, 1, 0);
      addVec(0, 1, 16'h1234, 0, 0, 0, 3,  1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 71, 8'h00, 4'h0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  5, 8'h66, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  1, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h1234, 0, 0, 0, 0,  1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 65, 8'h00, 4'h0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  2, 8'h66, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  1, 8'h00, 4'h0, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 20, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h0001, 0, 0, 0, 15, 1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 32, 8'h06, 4'h8, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 16, 8'h00, 4'h0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  2, 8'h06, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h3F, 4'h2, 0, 0);
      addVec(0, 1, 16'h0005, 0, 0, 1, 15, 1, 8'h3F, 4'h2, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 51, 8'h00, 4'h0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  2, 8'h6D, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h3F, 4'h2, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h00, 4'h0, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h0105, 0, 0, 1, 15, 1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 15, 8'h00, 4'h0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 38, 8'h06, 4'h4, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h1234, 0, 8, 0, 15, 1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 71, 8'h00, 4'h0, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 72, 8'h06, 4'h8, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 72, 8'h00, 4'h0, 0, 0);
      addVec(0, 1, 16'h1234, 4, 0, 0, 15, 1, 8'h00, 4'h0, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 53, 8'hDB, 4'h4, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 18, 8'h06, 4'h8, 0, 0);
      addVec(0, 1, 16'h1234, 4, 0, 0, 15, 1, 8'h06, 4'h8, 0, 1);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 56, 8'hDB, 4'h4, 0, 0);
      addVec(0, 1, 16'h1234, 0, 0, 0, 15, 1, 8'hDB, 4'h4, 0, 1);
      addVec(1, 0, 16'h0000, 0, 0, 0, 0,  1, 8'h00, 4'h0, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0,  3, 8'h3F, 4'h1, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 0, 15, 8'h3F, 4'h1, 0, 0);

      foreach (vecs[i]) begin
         for (int e = 0; e < vecs[i].edges; e++)
            applyStimulus(vecs[i].rst, vecs[i].load && (e == 0), vecs[i].cfg);
         checkOutput($sformatf("vec%0d_seven", i), seven, vecs[i].exp_seven);
         checkOutput($sformatf("vec%0d_segment", i), {4'h0, segment}, {4'h0, vecs[i].exp_segment});
         checkOutput($sformatf("vec%0d_tick", i), {7'h0, frame_tick}, {7'h0, vecs[i].exp_tick});
         checkOutput($sformatf("vec%0d_upd", i), {7'h0, upd_pending}, {7'h0, vecs[i].exp_upd});
      end

      // Random loads (including some on boundaries) and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         rc = mcfg_t'($urandom);
         applyStimulus(($urandom_range(0, 599) == 0), ($urandom_range(0, 29) == 0), rc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan scheduler for the board's 4-digit multiplexed seven-segment display. It time-shares the common segment bus among the four digits and inserts an anti-ghosting dead time between digits. It also applies PWM brightness, per-digit blink and leading-zero blanking. Display content is double-buffered so updates from the timer take effect only at frame boundaries, which prevents tearing.

## Interface
- `DEAD_CYCLES`, 256: dark cycles at the start of each digit slot; must be ≥ 1.
- `STEP_CYCLES`, 1024: cycles per brightness step. Each slot has 16 steps, so slot length = DEAD_CYCLES + 16·STEP_CYCLES.
- `BLINK_CYCLES`, 13500000: blink half-period request interval (0.5 s at 27 MHz).
- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: one-cycle strobe that captures all config inputs below.
- `digits` in 16: nibble i drives digit i. [3:0] = s1, [7:4] = s10, [11:8] = m1, [15:12] = m10.
- `dp_mask` in 4: decimal point enable per digit.
- `blink_mask` in 4: digits that blink.
- `blank_lz` in 1: leading-zero blanking enable.
- `bright` in 4: brightness level, 0 = 1/16 duty, 15 = full.
- `seven` out 8: [6:0] = gfedcba and [7] = dp, all active-high.
- `segment` out 4: one-hot digit enable, active-high.
- `upd_pending` out 1: a captured update is waiting for the next frame boundary.
- `frame_tick` out 1: one-cycle pulse on the first output cycle of slot 0.

## Operation
- **Scan position.** The free-running scan position is (slot 0..3, cycle within slot).
  - Slot order: 0, 1, 2, 3, then wrap.
  - Frame boundary = cycle 0 of slot 0.
- **Per-slot phases**, with c = cycle in slot:
  - DEAD: c < DEAD_CYCLES.
  - ON: step k = (c − DEAD_CYCLES)/STEP_CYCLES satisfies k ≤ active bright.
  - OFF: otherwise.
- **Outputs during DEAD or OFF, or for a dark digit:** `segment` = 0 and `seven` = 0.
- **Outputs during ON:** `segment` = 1<<slot. `seven` = {active dp_mask[slot], font(active digit[slot])}.
- **Font:** standard hex font. 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **A digit is dark if either condition holds:**
  - Blink: blink_phase = 1 and active blink_mask[slot] = 1.
  - Leading zero:
    - blank_lz = 1 and digit3 = 0 → digit 3 is dark.
    - Additionally, digit3 = 0 and digit2 = 0 → digit 2 is dark.
    - Digits 1 and 0 are never blanked.
- **Double buffer:**
  - `load` copies the inputs to the pending registers and sets `upd_pending`.
  - At a frame boundary with pending set, pending is copied to active and `upd_pending` is cleared.
  - `load` asserted on a boundary cycle bypasses pending: the inputs go straight to active, and `upd_pending` stays or becomes 0.
  - Repeated loads before a boundary: the last one wins.
- **Blink:**
  - The blink counter runs freely from 0 to BLINK_CYCLES−1.
  - On wrap it sets a toggle request.
  - blink_phase toggles only at a frame boundary, consuming the request. A digit is therefore never partially blinked within a frame.

## Timing
- Outputs are registered. `seven`/`segment` reflect the scan position of the previous cycle (1-cycle latency).
- `frame_tick` is aligned with the first `seven`/`segment` output of slot 0.
- New content after `load`:
  - Visible on outputs one cycle after the boundary that applies it.
  - Worst case is one frame + 1 cycle.
- Frame = 4·(DEAD_CYCLES + 16·STEP_CYCLES) = 66560 cycles with default parameters (≈405 Hz).
- Reset values:
  - `seven` = 0, `segment` = 0, `upd_pending` = 0, `frame_tick` = 0.
  - Scan position = slot 0, cycle 0.
  - Active and pending digits/masks/blank_lz = 0; active bright = 15.
  - blink_phase = 0, blink counter = 0, toggle request = 0.
- The first cycle after `rst` falls is a frame boundary.
- `rst` mid-frame discards pending and active content immediately; outputs are 0 on the next cycle.
- `rst` has priority over `load`.

## Structure
- Package `seg_pkg` holds:
  - the hex font constant;
  - the slot/phase enum (DEAD, ON, OFF);
  - the default parameter values shared with top-level instantiation.
- Sub-module `seg_font`: combinational nibble→7-bit lookup. All counters, buffering and the phase FSM stay in `seg_scan_ctrl`.

## Test plan
All scenarios use DEAD_CYCLES = 2, STEP_CYCLES = 1, BLINK_CYCLES = 40, giving slot = 18 and frame = 72 cycles.
- **Reset and first frame.** After reset, load digits = 16'h1234, bright = 15 on the boundary cycle → per slot: 2 dark cycles, then 16 cycles of `segment` = 0001 with `seven` = 66 (digit 4). Slots 1, 2 and 3 show 4F, 5B, 06. `frame_tick` pulses once per 72 cycles.
- **Brightness.** bright = 3 → exactly 4 ON cycles per slot, then 12 cycles of `segment` = 0. bright = 0 → 1 ON cycle.
- **Double buffer.** Load 16'h0001 mid-slot 1 → `upd_pending` = 1 until the boundary. Old content completes the frame. The new content appears at the next boundary + 1.
- **Leading zero.** blank_lz = 1, digits = 16'h0005 → slots 3 and 2 are dark; slot 1 shows 3F and slot 0 shows 6D. With digits = 16'h0105, only slot 3 is dark.
- **Blink.** blink_mask = 4'b1000 → slot 3 goes dark and lit in alternate blink periods. Every change occurs at a frame boundary; no frame is half-blanked.
- **dp and reset.** dp_mask = 4'b0100 → `seven[7]` = 1 only in slot 2. Asserting `rst` mid-slot 2 → next cycle all outputs are 0 and `upd_pending` = 0.
